cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical memory port between the instruction-fetch cache (I side) and the mem-stage data cache (D side) of the pipelined lc3b core.
- Latches one request at grant and holds it on the memory port until the memory responds, then hands off to the other requester.
- Routes the response back to the owner, and discards it if the owner has withdrawn its request (for example after a pipeline flush).

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, data width of one memory transfer (cache line).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_read  in  1  I-side read request, level, held until i_resp
- i_address  in  ADDR_W  I-side line address
- i_rdata  out  LINE_W  I-side read data
- i_resp  out  1  I-side completion pulse
- d_read  in  1  D-side read request, level
- d_write  in  1  D-side write request, level; never asserted together with d_read
- d_address  in  ADDR_W  D-side line address
- d_wdata  in  LINE_W  D-side write data
- d_rdata  out  LINE_W  D-side read data
- d_resp  out  1  D-side completion pulse
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory completion pulse, one cycle
- owner  out  2  00 = idle, 01 = I granted, 10 = D granted
- busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, SERVE_I, SERVE_D.
- Reset (asynchronous): state IDLE; all latches 0; every output 0.
- IDLE arbitration:
  - d_read or d_write pending -> SERVE_D (D has priority).
  - else i_read pending -> SERVE_I.
  - else stay in IDLE.
  - On the transition edge, latch op (read/write), address and wdata of the winner.
- SERVE_x outputs:
  - pmem_read/pmem_write/pmem_address/pmem_wdata are driven only from the latches, never from live inputs.
  - Strobes stay asserted until pmem_resp.
  - Latches never change while in SERVE.
- Response routing, combinational in the pmem_resp cycle:
  - x_resp = pmem_resp AND the owner's request is still asserted.
  - x_rdata = pmem_rdata is always driven; it is valid only while x_resp is high.
  - Non-owner resp is 0.
- Withdrawal: if the owner drops its request while in SERVE:
  - The memory transaction continues to completion; it is never aborted.
  - The response is swallowed: no x_resp.
  - The arbiter then proceeds as normal.
- Exit edge (the edge on which pmem_resp = 1):
  - The just-served requester is excluded from arbitration, since it may still hold its request this cycle.
  - If the other side is pending, go directly to its SERVE state and latch its request. Strobes stay high with no idle gap; the new address appears the cycle after the response.
  - Otherwise go to IDLE.
- Latency:
  - A request in IDLE sees strobes one cycle later.
  - The response is returned in the same cycle as pmem_resp.
  - Zero-wait memory: minimum request-to-resp time is 2 cycles.
- Fairness: alternation on the exit edge bounds the wait of either side to one foreign transaction.
- Simultaneous events:
  - Both sides requesting in IDLE -> D is served first, I next.
  - pmem_resp while in IDLE is ignored.
- Reset mid-transaction:
  - Immediate return to IDLE; strobes drop asynchronously; no resp is issued.
  - After reset release, a held request is re-arbitrated as new.
- owner/busy are registered from state: owner=01 in SERVE_I, 10 in SERVE_D, 00 in IDLE.

Test Plan:
- Lone I read, addr 0x1230, memory responds 3 cycles later with data 0xA5..A5.
  - pmem_read high from cycle 1, pmem_address = 0x1230.
  - i_resp = 1 with i_rdata = 0xA5..A5 in the resp cycle.
  - IDLE next cycle, d_resp never asserted.
- I read 0x0100 and D write 0x0200 (wdata 0xDEAD...) raised in the same cycle.
  - D is granted first, with pmem_write and address 0x0200.
  - On the edge after d_resp, pmem_read to address 0x0100 with no idle cycle between.
  - i_resp follows the second pmem_resp.
- D requests continuously back-to-back while I is pending.
  - Grants alternate D, I, D.
  - I is never bypassed twice.
- I read granted, then i_read dropped before pmem_resp.
  - pmem_read stays high until pmem_resp.
  - i_resp stays 0, and the arbiter is IDLE afterwards.
- D read in progress, D side changes d_address to 0x0FFF mid-transaction.
  - pmem_address keeps the latched value.
- reset asserted during SERVE_D.
  - Same cycle, asynchronously: pmem_read=0, owner=00, busy=0.
  - After release, the held d_read is re-granted one cycle later.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one physical memory port between the instruction cache (I side)
//   and the data cache (D side). One request is latched at grant and held on
//   the memory port until pmem_resp. The response goes back to the owner, or is
//   dropped if the owner has withdrawn its request. D has priority in IDLE.
//   On the response edge the arbiter switches straight to the other side if it
//   is waiting, which bounds either side's wait to one foreign transaction.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   i_read/i_address      I-side read request (level) and line address
//   i_rdata/i_resp        I-side read data and completion pulse
//   d_read/d_write        D-side read / write request (level, mutually exclusive)
//   d_address/d_wdata     D-side line address and write data
//   d_rdata/d_resp        D-side read data and completion pulse
//   pmem_*                memory port (strobes held until pmem_resp)
//   owner                 00 idle, 01 I granted, 10 D granted
//   busy                  arbiter is serving a request
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        owner,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;

  logic d_pending;
  assign d_pending = d_read | d_write;

  // State register and request latches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Next-state and latch-load logic
  always_comb begin
    logic load_i, load_d;
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_i     = 1'b0;
    load_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (d_pending)   load_d = 1'b1;
        else if (i_read) load_i = 1'b1;
      end
      StServeI: begin
        // The served side may still hold its request this cycle, so only the
        // other side is considered on the exit edge.
        if (pmem_resp) begin
          if (d_pending) load_d = 1'b1;
          else           state_d = StIdle;
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          if (i_read) load_i = 1'b1;
          else        state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_d) begin
      state_d    = StServeD;
      op_write_d = d_write;
      addr_d     = d_address;
      wdata_d    = d_wdata;
    end else if (load_i) begin
      state_d    = StServeI;
      op_write_d = 1'b0;
      addr_d     = i_address;
      wdata_d    = '0;
    end
  end

  // Outputs: memory port only from latches; responses gated by live request
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    owner        = 2'b00;
    busy         = 1'b0;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;

    unique case (state_q)
      StServeI: begin
        pmem_read = 1'b1;
        i_resp    = pmem_resp & i_read;
        owner     = 2'b01;
        busy      = 1'b1;
      end
      StServeD: begin
        pmem_read  = ~op_write_q;
        pmem_write = op_write_q;
        d_resp     = pmem_resp & d_pending;
        owner      = 2'b10;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LINE_W = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read, d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [1:0]        owner;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [LINE_W-1:0] DataA5  = {16{8'hA5}};
  localparam logic [LINE_W-1:0] DataDd  = {8{16'hDEAD}};
  localparam logic [LINE_W-1:0] Data3c  = {16{8'h3C}};

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .owner        (owner),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs are then changed and outputs
  // sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory port and status at once: {read, write, owner, busy}
  task automatic chk_port(input string tag, input logic rd, input logic wr,
                          input logic [1:0] own, input logic bsy);
    chk(tag, {pmem_read, pmem_write, owner, busy}, {rd, wr, own, bsy});
  endtask

  initial begin
    reset = 1'b1;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
    #1;
    chk_port("reset_state", 0, 0, 2'b00, 0);
    chk("reset_resp", {i_resp, d_resp}, 2'b00);
    step(); step();
    reset = 1'b0;
    step();

    // pmem_resp while idle is ignored
    pmem_resp = 1; #1;
    chk("idle_resp_ignored", {i_resp, d_resp}, 2'b00);
    step(); pmem_resp = 0; #1;
    chk_port("idle_after_stray_resp", 0, 0, 2'b00, 0);

    // Lone I read, memory answers on the third SERVE cycle
    i_read = 1; i_address = 16'h1230; #1;
    chk_port("i_req_not_yet", 0, 0, 2'b00, 0);
    step();
    chk_port("i_grant", 1, 0, 2'b01, 1);
    chk("i_grant_addr", pmem_address, 16'h1230);
    step();
    chk_port("i_wait1", 1, 0, 2'b01, 1);
    step();
    chk_port("i_wait2", 1, 0, 2'b01, 1);
    pmem_resp = 1; pmem_rdata = DataA5; #1;
    chk("i_resp_pulse", {i_resp, d_resp}, 2'b10);
    chk("i_rdata", i_rdata, DataA5);
    step();
    // i_read still held on the exit edge must not be re-granted
    chk_port("i_done_idle", 0, 0, 2'b00, 0);
    i_read = 0; pmem_resp = 0; #1;
    chk("i_done_no_resp", {i_resp, d_resp}, 2'b00);

    // Simultaneous I read and D write: D first, then I with no gap
    i_read = 1; i_address = 16'h0100;
    d_write = 1; d_address = 16'h0200; d_wdata = DataDd;
    step();
    chk_port("both_d_first", 0, 1, 2'b10, 1);
    chk("both_d_addr", pmem_address, 16'h0200);
    chk("both_d_wdata", pmem_wdata, DataDd);
    pmem_resp = 1; #1;
    chk("both_d_resp", {i_resp, d_resp}, 2'b01);
    step();
    d_write = 0; pmem_resp = 0; #1;
    chk_port("both_i_next", 1, 0, 2'b01, 1);
    chk("both_i_addr", pmem_address, 16'h0100);
    pmem_resp = 1; pmem_rdata = Data3c; #1;
    chk("both_i_resp", {i_resp, d_resp}, 2'b10);
    chk("both_i_rdata", i_rdata, Data3c);
    step();
    i_read = 0; pmem_resp = 0; #1;
    chk_port("both_idle", 0, 0, 2'b00, 0);

    // D back-to-back with I pending: D, I, D
    d_read = 1; d_address = 16'h0300; i_read = 1; i_address = 16'h0340;
    step();
    chk_port("alt_g1_d", 1, 0, 2'b10, 1);
    pmem_resp = 1; #1;
    chk("alt_g1_resp", {i_resp, d_resp}, 2'b01);
    step();
    pmem_resp = 0; #1;
    chk_port("alt_g2_i", 1, 0, 2'b01, 1);
    chk("alt_g2_addr", pmem_address, 16'h0340);
    pmem_resp = 1; #1;
    chk("alt_g2_resp", {i_resp, d_resp}, 2'b10);
    step();
    i_read = 0; pmem_resp = 0; #1;
    chk_port("alt_g3_d", 1, 0, 2'b10, 1);
    chk("alt_g3_addr", pmem_address, 16'h0300);
    pmem_resp = 1; #1;
    step();
    // D served on its exit edge and I is gone: back to IDLE
    chk_port("alt_idle", 0, 0, 2'b00, 0);
    d_read = 0; pmem_resp = 0;

    // I withdraws mid-transaction: transaction completes, resp swallowed
    i_read = 1; i_address = 16'h0500;
    step();
    chk_port("wd_grant", 1, 0, 2'b01, 1);
    i_read = 0; #1;
    chk_port("wd_strobe_held", 1, 0, 2'b01, 1);
    step();
    chk_port("wd_strobe_held2", 1, 0, 2'b01, 1);
    pmem_resp = 1; #1;
    chk("wd_swallowed", {i_resp, d_resp}, 2'b00);
    step();
    pmem_resp = 0; #1;
    chk_port("wd_idle", 0, 0, 2'b00, 0);

    // D address changes mid-transaction: latched value stays on the port
    d_read = 1; d_address = 16'h0400;
    step();
    chk("addr_latched", pmem_address, 16'h0400);
    d_address = 16'h0FFF; #1;
    chk("addr_hold_same_cycle", pmem_address, 16'h0400);
    step();
    chk("addr_hold_next_cycle", pmem_address, 16'h0400);
    chk_port("addr_still_d", 1, 0, 2'b10, 1);

    // Reset mid SERVE_D: asynchronous drop, then held request re-granted
    #2; reset = 1; #1;
    chk_port("rst_async", 0, 0, 2'b00, 0);
    pmem_resp = 1; #1;
    chk("rst_no_resp", {i_resp, d_resp}, 2'b00);
    pmem_resp = 0;
    step();
    reset = 0; #1;
    chk_port("rst_release_idle", 0, 0, 2'b00, 0);
    step();
    chk_port("rst_regrant", 1, 0, 2'b10, 1);
    chk("rst_regrant_addr", pmem_address, 16'h0FFF);
    pmem_resp = 1; #1;
    chk("rst_final_resp", {i_resp, d_resp}, 2'b01);
    step();
    d_read = 0; pmem_resp = 0; #1;
    chk_port("final_idle", 0, 0, 2'b00, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
